// File: rtl/regfile_wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } wb_req_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Tie-break winner: whichever requester did not win the previous tie.
  function automatic wb_req_t rr_pick(input wb_req_t last_grant);
    return (last_grant == REQ_MEM) ? REQ_ALU : REQ_MEM;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback holding slot: valid/ready intake, age bit, clear on grant.
module wb_slot
  import regfile_wb_pkg::*;
#(
  parameter int unsigned XLEN   = regfile_wb_pkg::XLEN,
  parameter int unsigned REG_AW = regfile_wb_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [XLEN-1:0]   i_data,
  input  logic              i_grant,
  input  logic              i_other_held,
  output logic              o_full,
  output logic              o_age,
  output logic [REG_AW-1:0] o_rd,
  output logic [XLEN-1:0]   o_data
);

  logic              r_full;
  logic              r_age;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_data;
  logic              w_ready;
  logic              w_load;

  assign w_ready = reset_n && (!r_full || i_grant);
  assign w_load  = i_valid && w_ready;

  // Age is relative: a newcomer is younger only if the other entry survives
  // this edge, and any entry that survives an edge becomes the older one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_age  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_age  <= i_other_held;
      r_rd   <= i_rd;
      r_data <= i_data;
    end else begin
      r_age <= 1'b0;
      if (i_grant) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_ready = w_ready;
  assign o_full  = r_full;
  assign o_age   = r_age;
  assign o_rd    = r_rd;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and load writeback paths onto the single register-file write port.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned XLEN   = regfile_wb_pkg::XLEN,
  parameter int unsigned REG_AW = regfile_wb_pkg::REG_AW
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     finish_flag,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [(1<<REG_AW)-1:0]   pending_mask
);

  logic              w_alu_full, w_alu_age;
  logic              w_mem_full, w_mem_age;
  logic [REG_AW-1:0] w_alu_rd, w_mem_rd;
  logic [XLEN-1:0]   w_alu_data, w_mem_data;
  logic              w_grant_alu, w_grant_mem, w_tie;
  logic              w_alu_held, w_mem_held;
  logic              w_any_grant;
  logic [REG_AW-1:0] w_sel_rd;
  logic [XLEN-1:0]   w_sel_data;
  wb_req_t           r_last_grant;

  assign w_alu_held = w_alu_full && !w_grant_alu;
  assign w_mem_held = w_mem_full && !w_grant_mem;

  wb_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_alu_slot (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_valid      (alu_valid),
    .o_ready      (alu_ready),
    .i_rd         (alu_rd),
    .i_data       (alu_data),
    .i_grant      (w_grant_alu),
    .i_other_held (w_mem_held),
    .o_full       (w_alu_full),
    .o_age        (w_alu_age),
    .o_rd         (w_alu_rd),
    .o_data       (w_alu_data)
  );

  wb_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mem_slot (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_valid      (mem_valid),
    .o_ready      (mem_ready),
    .i_rd         (mem_rd),
    .i_data       (mem_data),
    .i_grant      (w_grant_mem),
    .i_other_held (w_alu_held),
    .o_full       (w_mem_full),
    .o_age        (w_mem_age),
    .o_rd         (w_mem_rd),
    .o_data       (w_mem_data)
  );

  // Older entry (age 0) wins; equal ages mean same-edge acceptance -> round-robin.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    w_tie       = 1'b0;
    if (w_alu_full && w_mem_full) begin
      if (w_alu_age != w_mem_age) begin
        w_grant_alu = !w_alu_age;
        w_grant_mem = !w_mem_age;
      end else begin
        w_tie = 1'b1;
        if (rr_pick(r_last_grant) == REQ_ALU) begin
          w_grant_alu = 1'b1;
        end else begin
          w_grant_mem = 1'b1;
        end
      end
    end else begin
      w_grant_alu = w_alu_full;
      w_grant_mem = w_mem_full;
    end
  end

  assign w_any_grant = w_grant_alu || w_grant_mem;
  assign w_sel_rd    = w_grant_mem ? w_mem_rd   : w_alu_rd;
  assign w_sel_data  = w_grant_mem ? w_mem_data : w_alu_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we        <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
      r_last_grant <= REQ_MEM;
    end else begin
      rf_we <= w_any_grant && (w_sel_rd != '0) && !finish_flag;
      if (w_any_grant) begin
        rf_rd    <= w_sel_rd;
        rf_wdata <= w_sel_data;
      end
      if (w_tie) begin
        r_last_grant <= w_grant_alu ? REQ_ALU : REQ_MEM;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (w_alu_full) begin
      pending_mask[w_alu_rd] = 1'b1;
    end
    if (w_mem_full) begin
      pending_mask[w_mem_rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single-write vector table plus contention sequences.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        finish_flag = 1'b0;
  logic        alu_valid = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] alu_data = '0;
  logic [31:0] mem_data = '0;
  logic        alu_ready, mem_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  logic [31:0] regs [32] = '{default: '0};
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rf_we) regs[rf_rd] <= rf_wdata;
  end

  regfile_wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .finish_flag  (finish_flag),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Both sources handshake at the same edge; alu_first gives the expected tie winner.
  task automatic tie(input logic [4:0] ra, input logic [31:0] da,
                     input logic [4:0] rm, input logic [31:0] dm,
                     input logic alu_first, input string tag);
    logic [31:0] m;
    m = '0;
    m[ra] = 1'b1;
    m[rm] = 1'b1;
    alu_valid = 1'b1; alu_rd = ra; alu_data = da;
    mem_valid = 1'b1; mem_rd = rm; mem_data = dm;
    @(negedge clock);
    alu_valid = 1'b0; mem_valid = 1'b0;
    check({tag, "_mask_both"}, 64'(pending_mask), 64'(m));
    check({tag, "_alu_ready"}, 64'(alu_ready), 64'(alu_first));
    check({tag, "_mem_ready"}, 64'(mem_ready), 64'(!alu_first));
    @(negedge clock);
    check({tag, "_we1"}, 64'(rf_we), 64'd1);
    check({tag, "_rd1"}, 64'(rf_rd), alu_first ? 64'(ra) : 64'(rm));
    check({tag, "_data1"}, 64'(rf_wdata), alu_first ? 64'(da) : 64'(dm));
    check({tag, "_loser_ready"}, alu_first ? 64'(mem_ready) : 64'(alu_ready), 64'd1);
    m = '0;
    m[alu_first ? rm : ra] = 1'b1;
    check({tag, "_mask_one"}, 64'(pending_mask), 64'(m));
    @(negedge clock);
    check({tag, "_we2"}, 64'(rf_we), 64'd1);
    check({tag, "_rd2"}, 64'(rf_rd), alu_first ? 64'(rm) : 64'(ra));
    check({tag, "_data2"}, 64'(rf_wdata), alu_first ? 64'(dm) : 64'(da));
    check({tag, "_mask_none"}, 64'(pending_mask), 64'd0);
    @(negedge clock);
    check({tag, "_we_idle"}, 64'(rf_we), 64'd0);
  endtask

  typedef struct {
    logic        is_mem;
    logic        fin;
    wb_entry_t   ent;
    logic        exp_we;
    logic [31:0] exp_mask;
  } vec_t;

  vec_t vecs [6];

  initial begin
    wb_entry_t a_q [3];
    wb_entry_t m_q [3];
    wb_entry_t exp_q [6];
    int ai, mi, wi, first, last, we_seen, pend_seen;
    logic take_a, take_m;

    vecs[0] = '{is_mem: 1'b0, fin: 1'b0, ent: '{rd: 5'd5,  data: 32'h0000_1234}, exp_we: 1'b1, exp_mask: 32'h0000_0020};
    vecs[1] = '{is_mem: 1'b1, fin: 1'b0, ent: '{rd: 5'd31, data: 32'hDEAD_BEEF}, exp_we: 1'b1, exp_mask: 32'h8000_0000};
    vecs[2] = '{is_mem: 1'b0, fin: 1'b0, ent: '{rd: 5'd0,  data: 32'hFFFF_FFFF}, exp_we: 1'b0, exp_mask: 32'h0000_0000};
    vecs[3] = '{is_mem: 1'b1, fin: 1'b0, ent: '{rd: 5'd1,  data: 32'h0000_0000}, exp_we: 1'b1, exp_mask: 32'h0000_0002};
    vecs[4] = '{is_mem: 1'b0, fin: 1'b1, ent: '{rd: 5'd31, data: 32'h5555_AAAA}, exp_we: 1'b0, exp_mask: 32'h8000_0000};
    vecs[5] = '{is_mem: 1'b1, fin: 1'b1, ent: '{rd: 5'd0,  data: 32'h0000_0001}, exp_we: 1'b0, exp_mask: 32'h0000_0000};

    repeat (2) @(negedge clock);
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_rd", 64'(rf_rd), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_mask", 64'(pending_mask), 64'd0);
    reset_n = 1'b1;
    #1;
    check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      finish_flag = vecs[i].fin;
      if (vecs[i].is_mem) begin
        mem_valid = 1'b1; mem_rd = vecs[i].ent.rd; mem_data = vecs[i].ent.data;
      end else begin
        alu_valid = 1'b1; alu_rd = vecs[i].ent.rd; alu_data = vecs[i].ent.data;
      end
      #1;
      check($sformatf("vec%0d_ready", i), vecs[i].is_mem ? 64'(mem_ready) : 64'(alu_ready), 64'd1);
      @(negedge clock);
      alu_valid = 1'b0; mem_valid = 1'b0;
      check($sformatf("vec%0d_mask", i), 64'(pending_mask), 64'(vecs[i].exp_mask));
      check($sformatf("vec%0d_we_early", i), 64'(rf_we), 64'd0);
      @(negedge clock);
      check($sformatf("vec%0d_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_rd", i), 64'(rf_rd), 64'(vecs[i].ent.rd));
        check($sformatf("vec%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].ent.data));
      end
      check($sformatf("vec%0d_mask_clear", i), 64'(pending_mask), 64'd0);
      @(negedge clock);
      check($sformatf("vec%0d_we_once", i), 64'(rf_we), 64'd0);
      finish_flag = 1'b0;
    end

    tie(5'd3, 32'd7, 5'd4, 32'd9, 1'b1, "tie1");
    tie(5'd10, 32'hA, 5'd11, 32'hB, 1'b0, "tie2");

    // Same destination: MEM first, ALU one edge later; later write must land last.
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'd1;
    @(negedge clock);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'd2;
    check("samerd_mask0", 64'(pending_mask), 64'h40);
    check("samerd_alu_ready", 64'(alu_ready), 64'd1);
    @(negedge clock);
    alu_valid = 1'b0;
    check("samerd_we1", 64'(rf_we), 64'd1);
    check("samerd_data1", 64'(rf_wdata), 64'd1);
    check("samerd_mask1", 64'(pending_mask), 64'h40);
    @(negedge clock);
    check("samerd_we2", 64'(rf_we), 64'd1);
    check("samerd_data2", 64'(rf_wdata), 64'd2);
    check("samerd_mask2", 64'(pending_mask), 64'd0);
    @(negedge clock);
    check("samerd_final", 64'(regs[6]), 64'd2);
    check("samerd_we_idle", 64'(rf_we), 64'd0);

    // Both sources streaming: one write per cycle, alternating, ALU first.
    for (int k = 0; k < 3; k++) begin
      a_q[k] = '{rd: 5'(12 + k), data: 32'(32'h100 + 12 + k)};
      m_q[k] = '{rd: 5'(20 + k), data: 32'(32'h200 + 20 + k)};
      exp_q[2*k]   = a_q[k];
      exp_q[2*k+1] = m_q[k];
    end
    ai = 0; mi = 0; wi = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      alu_valid = (ai < 3);
      if (ai < 3) begin alu_rd = a_q[ai].rd; alu_data = a_q[ai].data; end
      mem_valid = (mi < 3);
      if (mi < 3) begin mem_rd = m_q[mi].rd; mem_data = m_q[mi].data; end
      #1;
      take_a = alu_valid && alu_ready;
      take_m = mem_valid && mem_ready;
      @(negedge clock);
      if (take_a) ai++;
      if (take_m) mi++;
      if (rf_we) begin
        if (wi < 6) begin
          check($sformatf("stream_rd%0d", wi), 64'(rf_rd), 64'(exp_q[wi].rd));
          check($sformatf("stream_data%0d", wi), 64'(rf_wdata), 64'(exp_q[wi].data));
        end
        if (first < 0) first = c;
        last = c;
        wi++;
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("stream_count", 64'(wi), 64'd6);
    check("stream_span", 64'(last - first), 64'd5);

    // finish_flag: accepted and drained, never written.
    finish_flag = 1'b1;
    ai = 0; we_seen = 0; pend_seen = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (ai < 4);
      alu_rd = 5'(ai + 1);
      alu_data = 32'(32'hF00 + ai);
      #1;
      take_a = alu_valid && alu_ready;
      @(negedge clock);
      if (take_a) ai++;
      if (rf_we) we_seen++;
      if (pending_mask != '0) pend_seen++;
    end
    alu_valid = 1'b0;
    check("fin_accepted", 64'(ai), 64'd4);
    check("fin_no_we", 64'(we_seen), 64'd0);
    check("fin_pending_cycles", 64'(pend_seen), 64'd4);
    check("fin_mask_empty", 64'(pending_mask), 64'd0);
    finish_flag = 1'b0;
    @(negedge clock);

    // Reset with both slots full: contents discarded, round-robin pointer restored.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
    @(negedge clock);
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("midrst_mask_full", 64'(pending_mask), 64'h180);
    reset_n = 1'b0;
    #1;
    check("midrst_alu_ready", 64'(alu_ready), 64'd0);
    check("midrst_mem_ready", 64'(mem_ready), 64'd0);
    check("midrst_we", 64'(rf_we), 64'd0);
    check("midrst_rd", 64'(rf_rd), 64'd0);
    check("midrst_wdata", 64'(rf_wdata), 64'd0);
    check("midrst_mask", 64'(pending_mask), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    we_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (rf_we) we_seen++;
    end
    check("midrst_no_we", 64'(we_seen), 64'd0);
    tie(5'd7, 32'h70, 5'd8, 32'h80, 1'b1, "tie_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
